// File: rtl/run_pause_sequencer.sv
// Run/pause sequencer for a 4-bit step counter: RUNS full sequences, then PAUSES off/on blinks.
// Optional macro STEP_PRESCALE_EN enables a PRESCALE clock divider on the counter advance enable.
module run_pause_sequencer #(
  parameter int unsigned RUNS       = 3,
  parameter int unsigned PAUSES     = 2,
  parameter int unsigned PAUSE_LEN  = 4,
  parameter int unsigned CONTINUOUS = 1,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       seq_last,
  output logic       en,
  output logic       oe,
  output logic       clr,
  output logic       busy,
  output logic       done,
  output logic [3:0] run_idx,
  output logic [3:0] pause_idx
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned TMR_W = 8;

  localparam logic [IDX_W-1:0] LAST_RUN   = IDX_W'(RUNS - 1);
  localparam logic [IDX_W-1:0] LAST_PAUSE = IDX_W'(PAUSES - 1);
  localparam logic [TMR_W-1:0] LAST_TMR   = TMR_W'(PAUSE_LEN - 1);

  // Elaboration-time range guard on the configuration.
  if (RUNS < 1 || RUNS > 15 || PAUSES < 1 || PAUSES > 15 ||
      PAUSE_LEN < 1 || PAUSE_LEN > 255 || PRESCALE < 1 || PRESCALE > 255) begin : g_param_chk
    $error("run_pause_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    P_OFF = 3'd3,
    P_ON  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] run_idx_n, pause_idx_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic             done_n, en_n, oe_n, clr_n, busy_n;

`ifdef STEP_PRESCALE_EN
  localparam logic [TMR_W-1:0] LAST_PRE = TMR_W'(PRESCALE - 1);
  logic [TMR_W-1:0] prescale, prescale_n;
`endif

  // Next-state, counter updates and output decode of the next state.
  always_comb begin
    state_n     = state;
    run_idx_n   = run_idx;
    pause_idx_n = pause_idx;
    timer_n     = timer;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) state_n = CLEAR;
      end
      CLEAR: begin
        state_n = RUN;
      end
      RUN: begin
        if (en && seq_last) begin
          if (run_idx == LAST_RUN) begin
            run_idx_n = '0;
            timer_n   = '0;
            state_n   = P_OFF;
          end else begin
            run_idx_n = run_idx + IDX_W'(1);
          end
        end
      end
      P_OFF: begin
        if (timer == LAST_TMR) begin
          timer_n = '0;
          state_n = P_ON;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      P_ON: begin
        if (timer == LAST_TMR) begin
          timer_n = '0;
          if (pause_idx == LAST_PAUSE) begin
            pause_idx_n = '0;
            done_n      = 1'b1;
            state_n     = (CONTINUOUS != 0) ? RUN : IDLE;
          end else begin
            pause_idx_n = pause_idx + IDX_W'(1);
            state_n     = P_OFF;
          end
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Abort wins over every transition above.
    if (stop && state != IDLE) begin
      state_n     = IDLE;
      run_idx_n   = '0;
      pause_idx_n = '0;
      timer_n     = '0;
      done_n      = 1'b0;
    end

`ifdef STEP_PRESCALE_EN
    prescale_n = '0;
    if (state_n == RUN && state == RUN) begin
      prescale_n = (prescale == LAST_PRE) ? '0 : prescale + TMR_W'(1);
    end
    en_n = (state_n == RUN) && (prescale_n == LAST_PRE);
`else
    en_n = (state_n == RUN);
`endif
    oe_n   = (state_n == RUN) || (state_n == P_ON);
    clr_n  = (state_n == CLEAR);
    busy_n = (state_n != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      run_idx   <= '0;
      pause_idx <= '0;
      timer     <= '0;
      en        <= 1'b0;
      oe        <= 1'b0;
      clr       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef STEP_PRESCALE_EN
      prescale  <= '0;
`endif
    end else begin
      state     <= state_n;
      run_idx   <= run_idx_n;
      pause_idx <= pause_idx_n;
      timer     <= timer_n;
      en        <= en_n;
      oe        <= oe_n;
      clr       <= clr_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef STEP_PRESCALE_EN
      prescale  <= prescale_n;
`endif
    end
  end

endmodule

// File: tb/tb_run_pause_sequencer.sv
// Directed bench for run_pause_sequencer: continuous and one-shot instances driven together,
// each with a 6-step counter model supplying seq_last.
module tb_run_pause_sequencer;

  logic clk;
  logic reset, start, stop, force_sl;
  int   cyc;
  int   total, bad;

  logic       en0, oe0, clr0, busy0, done0;
  logic [3:0] ri0, pi0;
  logic       en1, oe1, clr1, busy1, done1;
  logic [3:0] ri1, pi1;
  logic [2:0] c0 = '0, c1 = '0;
  logic       sl0, sl1;
  logic [12:0] o0, o1;

  assign sl0 = force_sl ? 1'b1 : (c0 == 3'd5);
  assign sl1 = force_sl ? 1'b1 : (c1 == 3'd5);
  assign o0  = {en0, oe0, clr0, busy0, done0, ri0, pi0};
  assign o1  = {en1, oe1, clr1, busy1, done1, ri1, pi1};

  run_pause_sequencer #(.CONTINUOUS(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .seq_last(sl0),
    .en(en0), .oe(oe0), .clr(clr0), .busy(busy0), .done(done0),
    .run_idx(ri0), .pause_idx(pi0));

  run_pause_sequencer #(.CONTINUOUS(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .seq_last(sl1),
    .en(en1), .oe(oe1), .clr(clr1), .busy(busy1), .done(done1),
    .run_idx(ri1), .pause_idx(pi1));

  // 6-value step counter models (index 0..5, last value raises seq_last)
  always @(posedge clk) begin
    if (reset || clr0) c0 <= '0;
    else if (en0) c0 <= (c0 == 3'd5) ? 3'd0 : c0 + 3'd1;
    if (reset || clr1) c1 <= '0;
    else if (en1) c1 <= (c1 == 3'd5) ? 3'd0 : c1 + 3'd1;
  end

`ifdef STEP_PRESCALE_EN
  logic       en2, oe2, clr2, busy2, done2;
  logic [3:0] ri2, pi2;
  logic [2:0] c2 = '0;
  logic       sl2;
  int         pstart = -1, p_en = 0, p_oe_bad = 0, p_first = -1;
  assign sl2 = (c2 == 3'd5);

  run_pause_sequencer #(.CONTINUOUS(1), .PRESCALE(3)) u2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .seq_last(sl2),
    .en(en2), .oe(oe2), .clr(clr2), .busy(busy2), .done(done2),
    .run_idx(ri2), .pause_idx(pi2));

  always @(posedge clk) begin
    if (reset || clr2) c2 <= '0;
    else if (en2) c2 <= (c2 == 3'd5) ? 3'd0 : c2 + 3'd1;
  end

  always @(negedge clk) begin
    if (pstart >= 0) begin
      if (cyc - pstart >= 2 && cyc - pstart < 56) begin
        if (en2) p_en++;
        if (!oe2) p_oe_bad++;
      end
      if (cyc - pstart >= 2 && p_first < 0 && busy2 && !oe2 && !clr2) p_first = cyc - pstart;
    end
  end
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          cyc;
    logic [12:0] e0;
    logic [12:0] e1;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [12:0] pk(input logic e, o, c, b, d, input int r, p);
    return {e, o, c, b, d, 4'(r), 4'(p)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 1: RUN with run_idx==1; mode 2: P_OFF (first); mode 3: P_ON with pause_idx==1
  task automatic wait_u0(input int mode, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((mode == 1 && en0 && ri0 == 4'd1) ||
          (mode == 2 && busy0 && !oe0 && !en0 && !clr0) ||
          (mode == 3 && busy0 && oe0 && !en0 && pi0 == 4'd1)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk($sformatf("wait_mode%0d_timeout", mode), 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int k;
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; force_sl = 1'b0;

    //                  cyc  en oe clr busy done ri pi   (u0)          (u1 one-shot)
    tbl.push_back('{ 1, pk(0,0,0,0,0,0,0), pk(0,0,0,0,0,0,0)});
    tbl.push_back('{ 2, pk(0,0,0,0,0,0,0), pk(0,0,0,0,0,0,0)});
    tbl.push_back('{ 3, pk(0,0,1,1,0,0,0), pk(0,0,1,1,0,0,0)});
    tbl.push_back('{ 4, pk(1,1,0,1,0,0,0), pk(1,1,0,1,0,0,0)});
    tbl.push_back('{ 9, pk(1,1,0,1,0,0,0), pk(1,1,0,1,0,0,0)});
    tbl.push_back('{10, pk(1,1,0,1,0,1,0), pk(1,1,0,1,0,1,0)});
    tbl.push_back('{15, pk(1,1,0,1,0,1,0), pk(1,1,0,1,0,1,0)});
    tbl.push_back('{16, pk(1,1,0,1,0,2,0), pk(1,1,0,1,0,2,0)});
    tbl.push_back('{21, pk(1,1,0,1,0,2,0), pk(1,1,0,1,0,2,0)});
    tbl.push_back('{22, pk(0,0,0,1,0,0,0), pk(0,0,0,1,0,0,0)});
    tbl.push_back('{25, pk(0,0,0,1,0,0,0), pk(0,0,0,1,0,0,0)});
    tbl.push_back('{26, pk(0,1,0,1,0,0,0), pk(0,1,0,1,0,0,0)});
    tbl.push_back('{29, pk(0,1,0,1,0,0,0), pk(0,1,0,1,0,0,0)});
    tbl.push_back('{30, pk(0,0,0,1,0,0,1), pk(0,0,0,1,0,0,1)});
    tbl.push_back('{33, pk(0,0,0,1,0,0,1), pk(0,0,0,1,0,0,1)});
    tbl.push_back('{34, pk(0,1,0,1,0,0,1), pk(0,1,0,1,0,0,1)});
    tbl.push_back('{37, pk(0,1,0,1,0,0,1), pk(0,1,0,1,0,0,1)});
    tbl.push_back('{38, pk(1,1,0,1,1,0,0), pk(0,0,0,0,1,0,0)});
    tbl.push_back('{39, pk(1,1,0,1,0,0,0), pk(0,0,0,0,0,0,0)});

    // Basic run and pause blink: reset in cycle 0, start in cycle 2.
    k = 0;
    for (int c = 0; c < 40; c++) begin
      reset = (c == 0);
      start = (c == 2);
      if (k < tbl.size() && tbl[k].cyc == c) begin
        chk($sformatf("tbl_u0_c%0d", c), 32'(o0), 32'(tbl[k].e0));
        chk($sformatf("tbl_u1_c%0d", c), 32'(o1), 32'(tbl[k].e1));
        k++;
      end
      tick();
    end

    // One-shot restart from IDLE; u0 is busy and must ignore the start.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("oneshot_restart_clr", 32'(o1), 32'(pk(0,0,1,1,0,0,0)));
    chk("start_while_busy",    32'(o0), 32'(pk(1,1,0,1,0,0,0)));
    tick();
    chk("oneshot_restart_run", 32'(o1), 32'(pk(1,1,0,1,0,0,0)));

    // Stop with start in RUN at run_idx==1, then start+stop together in IDLE.
    wait_u0(1, ok);
    start = 1'b1; stop = 1'b1;
    tick();
    chk("stop_in_run_u0", 32'(o0), 32'(pk(0,0,0,0,0,0,0)));
    chk("stop_in_run_u1", 32'(o1), 32'(pk(0,0,0,0,0,0,0)));
    tick();
    chk("start_stop_idle", 32'(o0), 32'(pk(0,0,0,0,0,0,0)));
    start = 1'b0; stop = 1'b0;

    // seq_last while idle must not move run_idx.
    force_sl = 1'b1;
    tick(); tick(); tick();
    chk("seq_last_in_idle", 32'(o0), 32'(pk(0,0,0,0,0,0,0)));
    force_sl = 1'b0;

    // Reset in the second P_ON; seq_last held high through the pause phase.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_u0(2, ok);
    force_sl = 1'b1;
    wait_u0(3, ok);
    chk("pon2_seq_last_ignored", 32'(o0), 32'(pk(0,1,0,1,0,0,1)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    force_sl = 1'b0;
    chk("reset_mid_pause_u0", 32'(o0), 32'(pk(0,0,0,0,0,0,0)));
    chk("reset_mid_pause_u1", 32'(o1), 32'(pk(0,0,0,0,0,0,0)));

`ifdef STEP_PRESCALE_EN
    // PRESCALE=3: 18 steps over 54 RUN cycles, P_OFF 56 cycles after start.
    start = 1'b1;
    pstart = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    chk("prescale_en_count", 32'(p_en), 32'd18);
    chk("prescale_oe_gaps", 32'(p_oe_bad), 32'd0);
    chk("prescale_poff_cycle", 32'(p_first), 32'd56);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
